// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side requests and memory-port signals of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_done;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_done;
  logic              d_stall;
  logic [31:0]       rdata;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  modport slave (
    input  if_req, if_addr, if_kill, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_done, if_stall, d_done, d_stall, rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, if_kill, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_done, if_stall, d_done, d_stall, rdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access with anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              discard_q, discard_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              if_want, d_win;
  logic [3:0]        d_be;
  // a waiting fetch outranks data once the data streak is exhausted
  assign if_want = bus.if_req && !bus.if_kill;
  assign d_win   = bus.d_req && !(if_want && streak_q == SW'(MAX_D_STREAK));
  assign d_be    = bus.d_size == 2'b00 ? 4'b0001 << bus.d_addr[1:0] :
                   bus.d_size == 2'b01 ? (bus.d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      discard_q <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      discard_q <= discard_d;
      streak_q  <= streak_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    discard_d = discard_q;
    streak_d  = streak_q;
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d  = DATA;
          addr_d   = bus.d_addr;
          we_d     = bus.d_we;
          be_d     = d_be;
          wdata_d  = bus.d_we ? bus.d_wdata : 32'h0;
          streak_d = if_want ? streak_q + SW'(1) : '0;
        end else if (if_want) begin
          state_d  = FETCH;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          be_d     = 4'b1111;
          wdata_d  = 32'h0;
          streak_d = '0;
        end
      end
      FETCH: begin
        state_d   = bus.mem_ready ? IDLE : FETCH;
        discard_d = (discard_q || bus.if_kill) && !bus.mem_ready;
      end
      DATA:    state_d = bus.mem_ready ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_req   = state_q != IDLE;
    bus.mem_addr  = addr_q;
    bus.mem_we    = we_q;
    bus.mem_be    = be_q;
    bus.mem_wdata = wdata_q;
    bus.rdata     = bus.mem_rdata;
    bus.if_done   = bus.mem_ready && state_q == FETCH && !discard_q && !bus.if_kill;
    bus.d_done    = bus.mem_ready && state_q == DATA;
    bus.if_stall  = bus.if_req && !bus.if_done;
    bus.d_stall   = bus.d_req && !bus.d_done;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int MS = 2;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(MS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int          m_own;
  logic [31:0] m_addr, m_wdata;
  logic        m_we, m_disc;
  logic [3:0]  m_be;
  int          m_streak;
  int          dones[$];
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (size == 2'd0) return 4'(1 << lane);
    if (size == 2'd1) return 4'(3 << (lane & 2));
    return 4'hF;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    logic exp_ifd, exp_dd;
    #1;
    exp_ifd = bus.mem_ready && m_own == 1 && !m_disc && !bus.if_kill;
    exp_dd  = bus.mem_ready && m_own == 2;
    chk("mem_req", 32'(bus.mem_req), 32'(m_own != 0));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    chk("mem_be", 32'(bus.mem_be), 32'(m_be));
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_done", 32'(bus.if_done), 32'(exp_ifd));
    chk("d_done", 32'(bus.d_done), 32'(exp_dd));
    chk("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !exp_ifd));
    chk("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !exp_dd));
    chk("rdata", bus.rdata, bus.mem_rdata);
    if (bus.if_done) dones.push_back(1);
    if (bus.d_done) dones.push_back(2);
  endtask
  task automatic adv();
    logic fw;
    @(posedge clk);
    fw = bus.if_req && !bus.if_kill;
    if (rst) begin
      m_own = 0; m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0; m_disc = 0; m_streak = 0;
    end else if (m_own == 0) begin
      if (bus.d_req && !(fw && m_streak == MS)) begin
        m_own = 2; m_addr = bus.d_addr; m_we = bus.d_we; m_be = be_of(bus.d_size, bus.d_addr);
        m_wdata = bus.d_we ? bus.d_wdata : 32'h0;
        m_streak = fw ? m_streak + 1 : 0;
      end else if (fw) begin
        m_own = 1; m_addr = bus.if_addr; m_we = 0; m_be = 4'hF; m_wdata = 0; m_streak = 0;
      end
    end else begin
      if (m_own == 1 && bus.if_kill) m_disc = 1;
      if (bus.mem_ready) begin m_own = 0; m_disc = 0; end
    end
    @(negedge clk);
  endtask
  task automatic tick();
    settle();
    adv();
  endtask
  initial begin
    m_own = 0; m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0; m_disc = 0; m_streak = 0;
    rst = 1; bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 32'hDEADBEEF; bus.mem_ready = 0;
    @(negedge clk);
    adv();
    settle();
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    adv();
    rst = 0;
    // fetch, zero-wait
    bus.if_req = 1; bus.if_addr = 32'h100;
    settle();
    chk("f_stall_n", 32'(bus.if_stall), 32'h1);
    adv();
    bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
    settle();
    chk("f_addr", bus.mem_addr, 32'h100);
    chk("f_be", 32'(bus.mem_be), 32'hF);
    chk("f_done", 32'(bus.if_done), 32'h1);
    chk("f_rdata", bus.rdata, 32'h12345678);
    adv();
    bus.if_req = 0; bus.mem_ready = 0;
    tick();
    // byte store with two wait states
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 0; bus.d_addr = 32'h203; bus.d_wdata = 32'hAA000000;
    tick();
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 2);
      settle();
      chk("st_we", 32'(bus.mem_we), 32'h1);
      chk("st_be", 32'(bus.mem_be), 32'h8);
      chk("st_addr", bus.mem_addr, 32'h203);
      chk("st_wdata", bus.mem_wdata, 32'hAA000000);
      chk("st_done", 32'(bus.d_done), 32'(i == 2));
      adv();
    end
    // continuous competing requests
    bus.d_we = 0; bus.mem_ready = 1; bus.if_req = 1; bus.if_addr = 32'h400;
    dones.delete();
    for (int i = 0; i < 12; i++) tick();
    chk("order_len", 32'(dones.size()), 32'd6);
    if (dones.size() == 6) begin
      chk("order", {dones[0][3:0], dones[1][3:0], dones[2][3:0], dones[3][3:0], dones[4][3:0],
                    dones[5][3:0], 8'h0}, 32'h22122100);
    end
    // fetch killed while waiting
    bus.d_req = 0; bus.mem_ready = 0; bus.if_addr = 32'h300;
    tick();
    bus.if_kill = 1;
    tick();
    bus.if_kill = 0; bus.if_addr = 32'h340;
    tick();
    bus.mem_ready = 1;
    settle();
    chk("kill_req", 32'(bus.mem_req), 32'h1);
    chk("kill_nodone", 32'(bus.if_done), 32'h0);
    adv();
    bus.mem_ready = 0;
    tick();
    settle();
    chk("kill_next_addr", bus.mem_addr, 32'h340);
    adv();
    bus.mem_ready = 1;
    tick();
    // reset in DATA with a full streak pending
    bus.d_req = 1; bus.d_we = 1; bus.d_size = 2; bus.d_addr = 32'h44; bus.d_wdata = $urandom;
    tick();
    tick();
    bus.mem_ready = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; bus.d_we = 0;
    settle();
    chk("rr_req", 32'(bus.mem_req), 32'h0);
    chk("rr_be", 32'(bus.mem_be), 32'h0);
    chk("rr_addr", bus.mem_addr, 32'h0);
    adv();
    bus.mem_ready = 1;
    settle();
    chk("rr_data_wins", 32'(bus.d_done), 32'h1);
    adv();
    bus.if_req = 0; bus.d_req = 0; bus.mem_ready = 0;
    tick();
    // byte-enable table
    begin
      logic [1:0]  sz[3] = '{2'd1, 2'd1, 2'd2};
      logic [31:0] ad[3] = '{32'h6, 32'h5, 32'hB};
      logic [3:0]  be[3] = '{4'hC, 4'h3, 4'hF};
      for (int i = 0; i < 3; i++) begin
        bus.d_req = 1; bus.d_size = sz[i]; bus.d_addr = ad[i]; bus.mem_ready = 0;
        tick();
        bus.mem_ready = 1;
        settle();
        chk("be_tbl", 32'(bus.mem_be), 32'(be[i]));
        adv();
        bus.d_req = 0; bus.mem_ready = 0;
      end
    end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.if_req = $urandom_range(0, 3) != 0; bus.if_addr = $urandom;
      bus.if_kill = $urandom_range(0, 9) == 0;
      bus.d_req = $urandom_range(0, 2) != 0; bus.d_we = 1'($urandom); bus.d_size = 2'($urandom);
      bus.d_addr = $urandom; bus.d_wdata = $urandom;
      bus.mem_ready = 1'($urandom); bus.mem_rdata = $urandom;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the CPU's single unified memory port between the instruction-fetch stage and the data-access (MEM) stage. It grants one requester at a time and holds that requester's latched address, control and write data on the memory port until the memory completes. It returns completion pulses and stall signals to the pipeline, and prevents instruction fetch from being starved by back-to-back data accesses. It sits between the IF/MEM pipeline stages and the memory wrapper.

## Interface
- ADDR_W, 32, address width (data path fixed at 32 bits)
- MAX_D_STREAK, 2, maximum consecutive data grants while a fetch waits (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  pipeline flush; cancels pending/in-flight fetch
- if_done  out  1  fetch complete, rdata valid this cycle
- if_stall  out  1  if_req && !if_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data, already lane-aligned
- d_done  out  1  data access complete
- d_stall  out  1  d_req && !d_done
- rdata  out  32  = mem_rdata (valid with if_done/d_done)
- mem_req  out  1  memory transaction active
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  memory completes current transaction

## Operation
- States: IDLE, FETCH, DATA. Registers: state, latched addr/we/be/wdata, discard flag, streak counter (width clog2(MAX_D_STREAK+1)).
- IDLE: mem_req=0. Arbitration on the current requests:
  - d_req && !(if_req && !if_kill && streak==MAX_D_STREAK): go to DATA and latch the d_* fields. streak increments if if_req && !if_kill, else clears to 0.
  - Otherwise, if_req && !if_kill: go to FETCH, latch if_addr, we=0, be=1111, streak=0.
  - Otherwise stay in IDLE.
- FETCH/DATA: mem_req=1; mem_addr/we/be/wdata driven only from latched registers.
  - Input changes do not affect the port.
  - On mem_ready, return to IDLE.
- Completion is combinational: if_done = mem_ready && state==FETCH && !discard && !if_kill; d_done = mem_ready && state==DATA.
- The requester treats its req in the cycle after done as a new request. The arbiter samples it in IDLE.
- if_kill asserted in FETCH sets discard. The transaction runs to mem_ready, if_done stays low, and discard clears on exit. if_kill in IDLE blocks fetch arbitration for that cycle only.
- Data accesses are never killed.
- mem_be for data accesses:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}, with addr[0] ignored
  - word: 1111, with addr[1:0] ignored
- mem_wdata = latched d_wdata for stores, 0 for fetches/loads.
- When mem_req=0, mem_addr, mem_we, mem_be and mem_wdata hold their last values. Consumers ignore them.

## Timing
- Reset: state=IDLE, streak=0, discard=0. Outputs: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0.
- rst mid-transaction abandons the transaction. mem_req is 0 in the next cycle, with no done pulse.
- Request high at cycle N in IDLE → mem_req high from N+1.
- With a 0-wait memory (mem_ready at N+1), done at N+1 and IDLE at N+2.
- Minimum port occupancy is 2 cycles per access; peak throughput is 1 access per 2 cycles.
- Each wait state adds one cycle. mem_req stays high and the registers stay stable until mem_ready.
- Simultaneous if_req and d_req in IDLE: data wins unless streak==MAX_D_STREAK, in which case fetch wins.
- With continuous data requests, at most MAX_D_STREAK data accesses run before a waiting fetch is served.
- mem_ready outside FETCH/DATA is ignored.
- if_kill in the same cycle as mem_ready in FETCH: if_done=0.

## Test plan
- Fetch only, if_addr=0x100, 0-wait memory:
  - mem_req, mem_addr=0x100, be=1111 at N+1; if_done=1 with rdata=mem_rdata at N+1; if_stall=1 at N.
- Store byte d_addr=0x203, d_wdata=0xAA000000, with 2 wait states:
  - mem_we=1, mem_be=1000, mem_addr stable for 3 cycles; d_done only on the mem_ready cycle.
- if_req and d_req held continuously, MAX_D_STREAK=2:
  - Grant order DATA, DATA, FETCH, DATA, DATA, FETCH.
  - if_stall high until each if_done.
- if_kill pulsed during FETCH wait state:
  - Transaction completes with mem_req held; no if_done.
  - Next IDLE grants the new if_addr.
- rst asserted in DATA before mem_ready:
  - mem_req=0, d_done=0 and all outputs at reset values next cycle.
  - Streak=0, verified by a subsequent simultaneous request granting DATA.
- Half load d_addr=0x006 → mem_be=1100; d_addr=0x005 half → mem_be=0011; word at 0x00B → mem_be=1111.
